mdu_ctrl: RTL

Multi-cycle multiply/divide sequencer attached to the EX stage. It accepts one MULT/MULTU/DIV/DIVU request from EX and iterates a shared 32-step shift-add / restoring-divide datapath. While busy it raises stallreq to the pipeline controller, then delivers a one-cycle HI/LO write. ID decodes the ops and forwards operands as ndata1/ndata2 on id_to_ex_bus; EX drives start/op.

---
 rtl/mdu_ctrl_pkg.sv | 36 +++
 rtl/mdu_ctrl_if.sv | 33 +++
 rtl/mdu_iter.sv | 45 ++++
 rtl/mdu_ctrl.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/mdu_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mdu_ctrl_pkg
// Purpose  : Shared op/state encodings and stall-bus constants for the MDU.
// Revision : 1.0 - initial release
// ============================================================================
package mdu_ctrl_pkg;

    localparam int         c_stall_w  = 6;
    localparam int         c_stall_ex = 3;
    localparam logic       c_stop     = 1'b1;
    localparam logic       c_nostop   = 1'b0;

    localparam logic [1:0] c_mdu_multu = 2'b00;
    localparam logic [1:0] c_mdu_mult  = 2'b01;
    localparam logic [1:0] c_mdu_divu  = 2'b10;
    localparam logic [1:0] c_mdu_div   = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_MUL   = 3'd1,
        S_DIV   = 3'd2,
        S_DZERO = 3'd3,
        S_DONE  = 3'd4
    } mdu_state_e;

    function automatic logic op_is_div(input logic [1:0] op);
        return op[1];
    endfunction

    function automatic logic op_is_signed(input logic [1:0] op);
        return op[0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/mdu_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : mdu_ctrl_if
// Purpose  : EX-stage <-> multiply/divide sequencer request and result bundle.
// Revision : 1.0 - initial release
// ============================================================================
interface mdu_ctrl_if
    import mdu_ctrl_pkg::*;
#(
    parameter int DATA_W = 32
);
    logic [c_stall_w-1:0] stall;
    logic                 start;
    logic [1:0]           op;
    logic [DATA_W-1:0]    src_a;
    logic [DATA_W-1:0]    src_b;
    logic                 stallreq;
    logic                 busy;
    logic                 hilo_we;
    logic [DATA_W-1:0]    hi_o;
    logic [DATA_W-1:0]    lo_o;

    modport master (
        output stall, start, op, src_a, src_b,
        input  stallreq, busy, hilo_we, hi_o, lo_o
    );

    modport slave (
        input  stall, start, op, src_a, src_b,
        output stallreq, busy, hilo_we, hi_o, lo_o
    );
endinterface
`default_nettype wire

// File: rtl/mdu_iter.sv
`default_nettype none
// ============================================================================
// Module   : mdu_iter
// Purpose  : One combinational step of shift-add multiply or restoring divide.
// Revision : 1.0 - initial release
// ============================================================================
module mdu_iter #(
    parameter int DATA_W = 32
) (
    input  wire logic              i_div,
    input  wire logic [DATA_W-1:0] i_opnd,
    input  wire logic [DATA_W-1:0] i_hi,
    input  wire logic [DATA_W-1:0] i_lo,
    output logic      [DATA_W-1:0] o_hi,
    output logic      [DATA_W-1:0] o_lo
);
    logic [DATA_W:0] w_sum;
    logic [DATA_W:0] w_rem_sh;
    logic [DATA_W:0] w_diff;
    logic            w_unused_diff;

    // Multiply: {hi, lo} holds {accumulator, remaining multiplier bits}.
    // Divide:   {hi, lo} holds {partial remainder, dividend/quotient bits}.
    always_comb begin
        w_sum    = {1'b0, i_hi} + {1'b0, i_opnd & {DATA_W{i_lo[0]}}};
        w_rem_sh = {i_hi, i_lo[DATA_W-1]};
        w_diff   = w_rem_sh - {1'b0, i_opnd};
        o_hi     = w_sum[DATA_W:1];
        o_lo     = {w_sum[0], i_lo[DATA_W-1:1]};
        if (i_div) begin
            if (w_rem_sh >= {1'b0, i_opnd}) begin
                o_hi = w_diff[DATA_W-1:0];
                o_lo = {i_lo[DATA_W-2:0], 1'b1};
            end else begin
                o_hi = w_rem_sh[DATA_W-1:0];
                o_lo = {i_lo[DATA_W-2:0], 1'b0};
            end
        end
    end

    // The subtract only happens when it cannot borrow past bit DATA_W-1.
    assign w_unused_diff = w_diff[DATA_W];

endmodule
`default_nettype wire

// File: rtl/mdu_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mdu_ctrl
// Purpose  : Multi-cycle MULT/MULTU/DIV/DIVU sequencer with HI/LO write strobe.
// Revision : 1.0 - initial release
// ============================================================================
module mdu_ctrl
    import mdu_ctrl_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 6
) (
    input  wire logic   clk,
    input  wire logic   rst,
    mdu_ctrl_if.slave   bus
);
    localparam logic [CNT_W-1:0] c_last = CNT_W'(DATA_W - 1);

    mdu_state_e        r_state;
    mdu_state_e        w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [1:0]        r_op;
    logic [DATA_W-1:0] r_opnd;
    logic [DATA_W-1:0] r_acc_hi;
    logic [DATA_W-1:0] r_acc_lo;
    logic [DATA_W-1:0] r_raw_a;
    logic [DATA_W-1:0] r_hi;
    logic [DATA_W-1:0] r_lo;
    logic              r_sign_q;
    logic              r_sign_r;
    logic              r_we;

    logic [DATA_W-1:0] w_nxt_hi;
    logic [DATA_W-1:0] w_nxt_lo;
    logic [DATA_W-1:0] w_mag_a;
    logic [DATA_W-1:0] w_mag_b;
    logic [DATA_W-1:0] w_fix_hi;
    logic [DATA_W-1:0] w_fix_lo;
    logic              w_stallreq;
    logic              w_a_neg;
    logic              w_b_neg;
    logic              w_unused_stall;

    assign w_a_neg = op_is_signed(bus.op) & bus.src_a[DATA_W-1];
    assign w_b_neg = op_is_signed(bus.op) & bus.src_b[DATA_W-1];
    assign w_mag_a = w_a_neg ? -bus.src_a : bus.src_a;
    assign w_mag_b = w_b_neg ? -bus.src_b : bus.src_b;

    mdu_iter #(
        .DATA_W (DATA_W)
    ) u_iter (
        .i_div  (r_state == S_DIV),
        .i_opnd (r_opnd),
        .i_hi   (r_acc_hi),
        .i_lo   (r_acc_lo),
        .o_hi   (w_nxt_hi),
        .o_lo   (w_nxt_lo)
    );

    // Sign fix-up applied to the final iteration's accumulators.
    always_comb begin
        w_fix_hi = w_nxt_hi;
        w_fix_lo = w_nxt_lo;
        if (!op_is_div(r_op)) begin
            if (r_sign_q) {w_fix_hi, w_fix_lo} = -{w_nxt_hi, w_nxt_lo};
        end else begin
            if (r_sign_q) w_fix_lo = -w_nxt_lo;
            if (r_sign_r) w_fix_hi = -w_nxt_hi;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_stallreq  = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_stallreq = bus.start;
                if (bus.start) begin
                    if (!op_is_div(bus.op))    w_state_nxt = S_MUL;
                    else if (bus.src_b == '0)  w_state_nxt = S_DZERO;
                    else                       w_state_nxt = S_DIV;
                end
            end
            S_MUL, S_DIV: begin
                w_stallreq = 1'b1;
                if (r_cnt == c_last) w_state_nxt = S_DONE;
            end
            S_DZERO: begin
                w_stallreq  = 1'b1;
                w_state_nxt = S_DONE;
            end
            S_DONE: begin
                // An externally stalled EX keeps start high; park here so it cannot re-issue.
                if (!(bus.stall[c_stall_ex] == c_stop && bus.start)) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt    <= '0;
            r_op     <= '0;
            r_opnd   <= '0;
            r_acc_hi <= '0;
            r_acc_lo <= '0;
            r_raw_a  <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_sign_q <= 1'b0;
            r_sign_r <= 1'b0;
            r_we     <= 1'b0;
        end else begin
            r_we <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_op     <= bus.op;
                        r_cnt    <= '0;
                        r_raw_a  <= bus.src_a;
                        r_sign_q <= w_a_neg ^ w_b_neg;
                        r_sign_r <= w_a_neg;
                        r_acc_hi <= '0;
                        if (!op_is_div(bus.op)) begin
                            r_opnd   <= w_mag_a;
                            r_acc_lo <= w_mag_b;
                        end else begin
                            r_opnd   <= w_mag_b;
                            r_acc_lo <= w_mag_a;
                        end
                    end
                end
                S_MUL, S_DIV: begin
                    r_acc_hi <= w_nxt_hi;
                    r_acc_lo <= w_nxt_lo;
                    r_cnt    <= r_cnt + 1'b1;
                    if (r_cnt == c_last) begin
                        r_cnt <= '0;
                        r_hi  <= w_fix_hi;
                        r_lo  <= w_fix_lo;
                        r_we  <= 1'b1;
                    end
                end
                S_DZERO: begin
                    r_hi <= r_raw_a;
                    r_lo <= '1;
                    r_we <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.stallreq = w_stallreq;
    assign bus.busy     = (r_state != S_IDLE);
    assign bus.hilo_we  = r_we;
    assign bus.hi_o     = r_hi;
    assign bus.lo_o     = r_lo;

    assign w_unused_stall = ^{bus.stall[c_stall_w-1:c_stall_ex+1], bus.stall[c_stall_ex-1:0]};

endmodule
`default_nettype wire
